// File: rtl/uart_stream_rx.sv
// UART receiver: synchronises UART_RX, oversamples at 4 ticks per bit and
// presents each byte with parity/frame flags on a one-entry AXI-Stream holding register.
module uart_stream_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cfg_en,
    input  logic        cfg_parity_en,
    input  logic        cfg_parity_odd,
    input  logic [27:0] cfg_div_i,
    input  logic [3:0]  cfg_div_q,
    input  logic        UART_RX,
    output logic        rx_tvalid,
    input  logic        rx_tready,
    output logic [7:0]  rx_tdata,
    output logic [1:0]  rx_tuser,
    output logic        rx_break,
    output logic        rx_overrun,
    output logic        rx_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs_prev_q, rxs_prev_d;
    state_t                 state_q, state_d;
    logic [27:0]            cnt_i_q, cnt_i_d;
    logic [3:0]             cnt_q_q, cnt_q_d;
    logic [1:0]             tick_n_q, tick_n_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   par_bit_q, par_bit_d;
    logic                   tvalid_q, tvalid_d;
    logic [7:0]             tdata_q, tdata_d;
    logic [1:0]             tuser_q, tuser_d;
    logic                   break_q, break_d;
    logic                   overrun_q, overrun_d;

    logic rxs_s;
    logic start_det_s;
    logic tick_s;
    logic sample_s;
    logic accept_s;
    logic ferr_s;

    assign rxs_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and previous-sample register for edge detection.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], UART_RX};
        rxs_prev_d = rxs_s;
        if (!cfg_en) begin
            sync_d     = {SYNC_STAGES{1'b1}};
            rxs_prev_d = 1'b1;
        end else begin
            rxs_prev_d = rxs_s;
        end
    end

    // Tick generator, frame FSM, completion and holding register.
    always_comb begin
        state_d     = state_q;
        cnt_i_d     = cnt_i_q;
        cnt_q_d     = cnt_q_q;
        tick_n_d    = tick_n_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        par_bit_d   = par_bit_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        break_d     = 1'b0;
        overrun_d   = 1'b0;
        tick_s      = 1'b0;
        ferr_s      = 1'b0;
        start_det_s = (state_q == ST_IDLE) && rxs_prev_q && !rxs_s;

        if (state_q != ST_IDLE) begin
            if (cnt_i_q == 28'd0) begin
                tick_s   = 1'b1;
                cnt_i_d  = (cnt_q_q < cfg_div_q) ? (cfg_div_i + 28'd1) : cfg_div_i;
                cnt_q_d  = cnt_q_q + 4'd1;
                tick_n_d = tick_n_q + 2'd1;
            end else begin
                cnt_i_d = cnt_i_q - 28'd1;
            end
        end else begin
            tick_s = 1'b0;
        end

        // The first tick after start detect is tick 1; samples fall on ticks 2, 6, 10, ...
        sample_s = tick_s && (tick_n_q == 2'd1);
        accept_s = tvalid_q && rx_tready;
        if (accept_s) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_det_s) begin
                    state_d   = ST_START;
                    cnt_i_d   = 28'd0;
                    cnt_q_d   = 4'd0;
                    tick_n_d  = 2'd0;
                    bit_cnt_d = 3'd0;
                    perr_d    = 1'b0;
                    par_bit_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    state_d = rxs_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_d   = {rxs_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = cfg_parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    par_bit_d = rxs_s;
                    perr_d    = rxs_s ^ parity8(shift_q) ^ cfg_parity_odd;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    state_d = ST_IDLE;
                    ferr_s  = !rxs_s;
                    if ((shift_q == 8'h00) && ferr_s && (!cfg_parity_en || !par_bit_q)) begin
                        break_d = 1'b1;
                    end else if (!tvalid_q || accept_s) begin
                        tvalid_d = 1'b1;
                        tdata_d  = shift_q;
                        tuser_d  = {ferr_s, perr_q};
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable behaves as a synchronous reset of every register.
        if (!cfg_en) begin
            state_d   = ST_IDLE;
            cnt_i_d   = 28'd0;
            cnt_q_d   = 4'd0;
            tick_n_d  = 2'd0;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            perr_d    = 1'b0;
            par_bit_d = 1'b0;
            tvalid_d  = 1'b0;
            tdata_d   = 8'h00;
            tuser_d   = 2'b00;
            break_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q     <= {SYNC_STAGES{1'b1}};
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_i_q    <= 28'd0;
            cnt_q_q    <= 4'd0;
            tick_n_q   <= 2'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            perr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= 8'h00;
            tuser_q    <= 2'b00;
            break_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rxs_prev_q <= rxs_prev_d;
            state_q    <= state_d;
            cnt_i_q    <= cnt_i_d;
            cnt_q_q    <= cnt_q_d;
            tick_n_q   <= tick_n_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            par_bit_q  <= par_bit_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            break_q    <= break_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_tvalid  = tvalid_q;
    assign rx_tdata   = tdata_q;
    assign rx_tuser   = tuser_q;
    assign rx_break   = break_q;
    assign rx_overrun = overrun_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_stream_rx.sv
// Scoreboard bench for uart_stream_rx: frames are driven on UART_RX, expected
// beats are queued, and a monitor process pops and compares on each handshake.
module tb_uart_stream_rx;

    logic        PCLK;
    logic        PRESETn;
    logic        cfg_en;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic [27:0] cfg_div_i;
    logic [3:0]  cfg_div_q;
    logic        UART_RX;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  rx_tdata;
    logic [1:0]  rx_tuser;
    logic        rx_break;
    logic        rx_overrun;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;
    int break_cycles = 0;
    int overrun_cycles = 0;
    bit busy_seen = 1'b0;
    logic [9:0] exp_q[$];

    uart_stream_rx #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .cfg_en(cfg_en),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_div_i(cfg_div_i), .cfg_div_q(cfg_div_q), .UART_RX(UART_RX),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
        .rx_tuser(rx_tuser), .rx_break(rx_break), .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [9:0] e;
        forever begin
            @(negedge PCLK);
            if (rx_busy) busy_seen = 1'b1;
            if (rx_break) break_cycles++;
            if (rx_overrun) overrun_cycles++;
            if (PRESETn && rx_tvalid && rx_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h/%0h expected none", rx_tuser, rx_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {22'd0, rx_tuser, rx_tdata}, {22'd0, e});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Drives one line bit; bit_x2 is the bit time in half PCLK cycles.
    task automatic drive_bit(input logic v, input int k, input int bit_x2);
        UART_RX = v;
        idle(((k + 1) * bit_x2) / 2 - (k * bit_x2) / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_v,
                              input logic stop_v, input int bit_x2);
        int k;
        k = 0;
        drive_bit(1'b0, k, bit_x2); k++;
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], k, bit_x2); k++;
        end
        if (par_en) begin
            drive_bit(par_v, k, bit_x2); k++;
        end
        drive_bit(stop_v, k, bit_x2);
        UART_RX = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge PCLK);
            n++;
        end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_tvalid"}, {31'd0, rx_tvalid}, 0);
        chk({nm, "_tdata"}, {24'd0, rx_tdata}, 0);
        chk({nm, "_tuser"}, {30'd0, rx_tuser}, 0);
        chk({nm, "_busy"}, {31'd0, rx_busy}, 0);
        chk({nm, "_pulses"}, {30'd0, rx_break, rx_overrun}, 0);
    endtask

    initial begin
        int brk0;
        int ovr0;
        PRESETn = 1'b0; cfg_en = 1'b1; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        cfg_div_i = 28'd3; cfg_div_q = 4'd0; UART_RX = 1'b1; rx_tready = 1'b1;
        fork
            monitor_loop();
        join_none
        idle(3);
        check_outputs_zero("reset");
        PRESETn = 1'b1;
        idle(5);

        // 8N1 at 16 PCLK/bit, single then back-to-back
        exp_q.push_back({2'b00, 8'h55});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 32);
        idle(40);
        exp_q.push_back({2'b00, 8'h00});
        exp_q.push_back({2'b00, 8'hFF});
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 32);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 32);
        idle(40);
        wait_drain();

        // Parity: even correct, even flipped, odd correct
        cfg_parity_en = 1'b1;
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 32);
        exp_q.push_back({2'b01, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 32);
        idle(40);
        cfg_parity_odd = 1'b1;
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 32);
        idle(40);
        wait_drain();
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        idle(5);

        // Frame error, then break
        exp_q.push_back({2'b10, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 32);
        idle(40);
        wait_drain();
        chk("no_break_yet", break_cycles, 0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 32);
        idle(40);
        chk("break_pulse", break_cycles, 1);
        chk("break_no_data", {31'd0, rx_tvalid}, 0);

        // Backpressure and overrun
        rx_tready = 1'b0;
        ovr0 = overrun_cycles;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 32);
        idle(20);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 32);
        idle(40);
        chk("overrun_pulse", overrun_cycles - ovr0, 1);
        chk("held_valid", {31'd0, rx_tvalid}, 1);
        chk("held_data", {24'd0, rx_tdata}, 32'h11);
        exp_q.push_back({2'b00, 8'h11});
        rx_tready = 1'b1;
        wait_drain();
        idle(2);
        chk("valid_after_accept", {31'd0, rx_tvalid}, 0);

        // Glitch: 3-cycle low pulse
        busy_seen = 1'b0;
        UART_RX = 1'b0;
        idle(3);
        UART_RX = 1'b1;
        idle(30);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 1);
        chk("glitch_busy_clear", {31'd0, rx_busy}, 0);
        chk("glitch_no_data", {31'd0, rx_tvalid}, 0);

        // Fractional divider: 2 + 8/16, line at 13.5 PCLK/bit
        cfg_div_i = 28'd2; cfg_div_q = 4'd8;
        exp_q.push_back({2'b00, 8'h96});
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 27);
        idle(40);
        wait_drain();
        cfg_div_i = 28'd3; cfg_div_q = 4'd0;
        idle(5);

        // Reset mid-frame with a byte held, then a clean frame
        for (int pass = 0; pass < 2; pass++) begin
            rx_tready = 1'b0;
            send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 32);
            idle(30);
            chk("pre_reset_held", {23'd0, rx_tvalid, rx_tdata}, {23'd0, 1'b1, 8'h5A});
            brk0 = break_cycles; ovr0 = overrun_cycles;
            UART_RX = 1'b0; idle(16);
            for (int i = 0; i < 4; i++) begin
                UART_RX = (i == 0) ? 1'b0 : 1'b1;
                idle(16);
            end
            UART_RX = 1'b1;
            idle(8);
            chk("midframe_busy", {31'd0, rx_busy}, 1);
            if (pass == 0) begin
                PRESETn = 1'b0;
                #1;
                check_outputs_zero("async_reset");
                idle(2);
                PRESETn = 1'b1;
            end else begin
                cfg_en = 1'b0;
                idle(1);
                check_outputs_zero("disable");
                idle(4);
                cfg_en = 1'b1;
            end
            idle(30);
            chk("no_pulse_after_abort", (break_cycles - brk0) + (overrun_cycles - ovr0), 0);
            rx_tready = 1'b1;
            exp_q.push_back({2'b00, 8'h7E});
            send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 32);
            idle(40);
            wait_drain();
        end

        chk("final_break_total", break_cycles, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
